data_mem_load_unit: RTL and testbench
=====================================

Name: data_mem_load_unit

Overview:
- Producer of the load-data writeback operand (data_mem_rd) for the register-unit write mux.
- Accepts a load request from the core, runs a valid/ready request and response exchange with a data memory that has wait states, then extracts and extends the addressed byte, halfword or word.
- Holds the core stalled until the load completes or fails.
- Sits between core control/ALU address output and the data memory bus.

Parameters:
- TIMEOUT, 16, maximum cycles spent in REQ+WAIT before the load is aborted with an error.
- ADDR_W, 32, byte address width.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- ld_req  in  1  load request, level; core holds it with addr/funct3 stable while ld_stall=1
- ld_addr  in  ADDR_W  byte address from ALU
- ld_funct3  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
- ld_stall  out  1  core must not advance
- ld_done  out  1  one-cycle pulse; ld_data valid
- ld_data  out  32 signed  extended load result, feeds data_mem_rd
- ld_err  out  1  one-cycle pulse; misaligned, illegal funct3, or timeout
- mem_req_valid  out  1  memory read request valid
- mem_req_ready  in  1  memory accepts request
- mem_addr  out  ADDR_W  word-aligned address {addr[ADDR_W-1:2],2'b00}
- mem_rsp_valid  in  1  response data valid
- mem_rsp_data  in  32  full word read from memory

Behaviour:
- Reset (async): state IDLE; all outputs 0; captured addr/funct3 cleared; timeout counter 0.
- FSM states: IDLE, REQ, WAIT, DONE, ERR.
- IDLE:
  - If ld_req=1, capture ld_addr and ld_funct3.
  - Illegal funct3 (011, 110, 111), LH/LHU with addr[0]=1, or LW with addr[1:0]!=0 -> ERR.
  - Otherwise -> REQ.
- REQ:
  - mem_req_valid=1; mem_addr held stable from captured addr.
  - On mem_req_valid & mem_req_ready -> WAIT.
  - mem_rsp_valid in REQ is ignored.
- WAIT: on mem_rsp_valid -> register the extracted result into ld_data, -> DONE.
- DONE: ld_done=1 for exactly one cycle; ld_data holds its value until the next DONE or ERR; -> IDLE.
- ERR: ld_err=1 for one cycle; ld_data=0; -> IDLE. Memory is never requested for misaligned or illegal loads.
- ld_stall:
  - 1 in IDLE when ld_req=1, and in REQ and WAIT.
  - 0 in DONE, ERR, and IDLE when ld_req=0.
- Minimum latency, with ready=1 and a response in the first WAIT cycle: ld_req seen in IDLE at cycle 0, REQ at 1, WAIT at 2, ld_done at cycle 3.
- Timeout:
  - The counter is cleared on leaving IDLE and increments each cycle in REQ or WAIT.
  - When it equals TIMEOUT -> ERR, and mem_req_valid drops.
  - Counter width is $clog2(TIMEOUT+1).
  - If mem_rsp_valid and timeout occur in the same cycle, the response wins and the state goes to DONE.
- Extraction (lane = captured addr[1:0]):
  - LB: sign-extend byte[lane].
  - LBU: zero-extend byte[lane].
  - LH: sign-extend halfword[addr[1]].
  - LHU: zero-extend halfword[addr[1]].
  - LW: full word.
  - Little-endian; byte0 = bits 7:0.
- Back-to-back loads: ld_req still high in the IDLE cycle after DONE is treated as a new request, because the core advanced during DONE.
- Reset mid-operation: returns to IDLE immediately and mem_req_valid drops asynchronously. A stale mem_rsp_valid arriving later in IDLE is ignored.

Decomposition:
- Shared package load_pkg:
  - funct3 constants LB_F3, LH_F3, LW_F3, LBU_F3, LHU_F3.
  - Typedef enum ld_state_t for the five states.
  - Function is_misaligned(funct3, addr[1:0]).
- Sub-module load_extend: purely combinational. Inputs word, lane, funct3; output 32-bit extended result. It is reused later by the store path checker.

Test Plan:
- LW addr 0x100, ready=1, rsp at first WAIT cycle with data 0xDEADBEEF -> ld_done at cycle 3, ld_data=0xDEADBEEF, mem_addr=0x100, ld_stall high cycles 0-2.
- LB addr 0x103 and LBU addr 0x103, word 0x80AB_CD12 -> LB gives 0xFFFFFF80, LBU gives 0x00000080; mem_addr=0x100 for both.
- LH addr 0x102, word 0x8001_7FFF -> 0xFFFF8001. LHU addr 0x100 on the same word -> 0x00007FFF.
- LW addr 0x101 -> ld_err pulse at cycle 1, mem_req_valid never asserted, ld_data=0. funct3=011 -> same result.
- Ready delayed 3 cycles, response 4 cycles later -> mem_addr stable through REQ, ld_done after 9 cycles total. With TIMEOUT=16 and no response -> ld_err at the 16th REQ/WAIT cycle. Response coinciding with the timeout cycle -> ld_done, not ld_err.
- rst asserted during WAIT, then mem_rsp_valid pulsed after release -> outputs 0 immediately, state IDLE, no ld_done.

Source files
------------

// File: rtl/load_pkg.sv
// Shared definitions for the data-memory load path.
// Contents:
//   - funct3 encodings of the supported loads (LB/LH/LW/LBU/LHU)
//   - ld_state_t: the five-state load FSM encoding
//   - is_illegal / is_misaligned: request screening helpers, evaluated
//     on the raw request so bad loads never reach the memory bus
package load_pkg;

  localparam logic [2:0] LB_F3  = 3'b000;
  localparam logic [2:0] LH_F3  = 3'b001;
  localparam logic [2:0] LW_F3  = 3'b010;
  localparam logic [2:0] LBU_F3 = 3'b100;
  localparam logic [2:0] LHU_F3 = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_DONE,
    ST_ERR
  } ld_state_t;

  // funct3 values that do not name a load
  function automatic logic is_illegal(input logic [2:0] funct3);
    case (funct3)
      LB_F3, LH_F3, LW_F3, LBU_F3, LHU_F3: return 1'b0;
      default:                             return 1'b1;
    endcase
  endfunction

  // Byte loads are always aligned; halfwords need an even address,
  // words a multiple of four.
  function automatic logic is_misaligned(input logic [2:0] funct3,
                                         input logic [1:0] lo);
    case (funct3)
      LH_F3, LHU_F3: return lo[0];
      LW_F3:         return lo != 2'b00;
      default:       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_extend.sv
// Combinational byte/halfword/word extraction and extension.
// Ports:
//   word   - full little-endian word read from memory (byte0 = bits 7:0)
//   lane   - byte offset within the word (addr[1:0])
//   funct3 - load type; LB/LH sign-extend, LBU/LHU zero-extend, LW passes
//   result - 32-bit extended value
// Shared with the store-path checker, so it carries no state.
module load_extend
  import load_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word[{lane, 3'b000} +: 8];
    half_sel = lane[1] ? word[31:16] : word[15:0];
    case (funct3)
      LB_F3:   result = {{24{byte_sel[7]}}, byte_sel};
      LBU_F3:  result = {24'h0, byte_sel};
      LH_F3:   result = {{16{half_sel[15]}}, half_sel};
      LHU_F3:  result = {16'h0, half_sel};
      default: result = word;
    endcase
  end

endmodule

// File: rtl/data_mem_load_unit.sv
// Load unit between the core (ALU address, funct3) and a wait-stated data
// memory. Screens the request, performs a valid/ready request and a
// response wait, extracts/extends the addressed data and returns it as the
// register-write operand. The core is stalled until DONE or ERR.
// Ports:
//   clk, rst                    - clock, async active-high reset
//   ld_req/ld_addr/ld_funct3    - load request (held stable while stalled)
//   ld_stall                    - core must not advance
//   ld_done/ld_data             - completion pulse and extended result
//   ld_err                      - pulse on misaligned/illegal/timeout
//   mem_req_valid/ready,mem_addr- word-aligned read request
//   mem_rsp_valid/mem_rsp_data  - read response
module data_mem_load_unit
  import load_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int ADDR_W  = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ld_req,
  input  logic [ADDR_W-1:0]   ld_addr,
  input  logic [2:0]          ld_funct3,
  output logic                ld_stall,
  output logic                ld_done,
  output logic signed [31:0]  ld_data,
  output logic                ld_err,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  input  logic                mem_rsp_valid,
  input  logic [31:0]         mem_rsp_data
);

  localparam int CW = $clog2(TIMEOUT + 1);

  ld_state_t         state;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        f3_q;
  logic [CW-1:0]     cnt;
  logic [31:0]       ext;
  logic              tmo;

  load_extend u_ext (
    .word   (mem_rsp_data),
    .lane   (addr_q[1:0]),
    .funct3 (f3_q),
    .result (ext)
  );

  // cnt counts completed REQ/WAIT cycles, so this flags the TIMEOUT-th
  // busy cycle: REQ+WAIT never lasts longer than TIMEOUT cycles.
  assign tmo = (cnt == CW'(TIMEOUT - 1));

  assign mem_addr = {addr_q[ADDR_W-1:2], 2'b00};

  // Stall in IDLE follows ld_req directly so the core freezes in the same
  // cycle it presents the load. Gated by rst so all outputs read 0 in reset.
  assign ld_stall = !rst && ((state == ST_IDLE && ld_req) ||
                             state == ST_REQ || state == ST_WAIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      addr_q        <= '0;
      f3_q          <= '0;
      cnt           <= '0;
      mem_req_valid <= 1'b0;
      ld_done       <= 1'b0;
      ld_err        <= 1'b0;
      ld_data       <= '0;
    end else begin
      ld_done <= 1'b0;
      ld_err  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (ld_req) begin
            addr_q <= ld_addr;
            f3_q   <= ld_funct3;
            cnt    <= '0;
            if (is_illegal(ld_funct3) || is_misaligned(ld_funct3, ld_addr[1:0])) begin
              state   <= ST_ERR;
              ld_err  <= 1'b1;
              ld_data <= '0;
            end else begin
              state         <= ST_REQ;
              mem_req_valid <= 1'b1;
            end
          end
        end
        ST_REQ: begin
          cnt <= cnt + CW'(1);
          // Timeout beats a late handshake: once the budget is spent the
          // request is withdrawn rather than entering WAIT with no cycles left.
          if (tmo) begin
            state         <= ST_ERR;
            mem_req_valid <= 1'b0;
            ld_err        <= 1'b1;
            ld_data       <= '0;
          end else if (mem_req_ready) begin
            state         <= ST_WAIT;
            mem_req_valid <= 1'b0;
          end
        end
        ST_WAIT: begin
          cnt <= cnt + CW'(1);
          // A response in the timeout cycle still completes the load.
          if (mem_rsp_valid) begin
            state   <= ST_DONE;
            ld_done <= 1'b1;
            ld_data <= ext;
          end else if (tmo) begin
            state   <= ST_ERR;
            ld_err  <= 1'b1;
            ld_data <= '0;
          end
        end
        ST_DONE: state <= ST_IDLE;
        ST_ERR:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_load_unit.sv
// Self-checking bench for data_mem_load_unit. A timeline model derives,
// for every cycle of a load, the expected stall/request/done/err/data
// values from the request legality, memory ready delay and response delay.
module tb_data_mem_load_unit;

  localparam int T = 16;

  logic               clk = 1'b0;
  logic               rst;
  logic               ld_req;
  logic [31:0]        ld_addr;
  logic [2:0]         ld_funct3;
  logic               ld_stall;
  logic               ld_done;
  logic signed [31:0] ld_data;
  logic               ld_err;
  logic               mem_req_valid;
  logic               mem_req_ready;
  logic [31:0]        mem_addr;
  logic               mem_rsp_valid;
  logic [31:0]        mem_rsp_data;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_data = '0;

  data_mem_load_unit #(.TIMEOUT(T), .ADDR_W(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .ld_req        (ld_req),
    .ld_addr       (ld_addr),
    .ld_funct3     (ld_funct3),
    .ld_stall      (ld_stall),
    .ld_done       (ld_done),
    .ld_data       (ld_data),
    .ld_err        (ld_err),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_addr      (mem_addr),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit ref_legal(input logic [2:0] f3, input logic [31:0] a);
    case (f3)
      3'd0, 3'd4: return 1'b1;
      3'd1, 3'd5: return (a % 2) == 0;
      3'd2:       return (a % 4) == 0;
      default:    return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] ref_ext(input logic [2:0] f3, input logic [31:0] a,
                                          input logic [31:0] w);
    longint v;
    int unsigned lane;
    lane = a % 4;
    case (f3)
      3'd0, 3'd4: begin
        v = longint'((w >> (8 * lane)) % 256);
        if (f3 == 3'd0 && v >= 128) v = v - 256;
      end
      3'd1, 3'd5: begin
        v = longint'((w >> (16 * (lane / 2))) % 65536);
        if (f3 == 3'd1 && v >= 32768) v = v - 65536;
      end
      default: v = longint'(w);
    endcase
    return 32'(v);
  endfunction

  // One load. Cycle 0 is the IDLE cycle presenting the request; ready is
  // given in REQ cycle rd+1, the response in busy cycle rd+wd+2.
  task automatic run_load(input logic [31:0] a, input logic [2:0] f3, input logic [31:0] w,
                          input int rd, input int wd, input bit hold_req, input string tag);
    bit legal, ok;
    int req_end, busy_end;
    bit exp_mrv, real_rsp;
    legal = ref_legal(f3, a);
    if (!legal) begin
      req_end = 0; busy_end = 0; ok = 1'b0;
    end else if (rd + 1 >= T) begin
      req_end = T; busy_end = T; ok = 1'b0;
    end else begin
      req_end = rd + 1;
      if (rd + wd + 2 <= T) begin busy_end = rd + wd + 2; ok = 1'b1; end
      else begin busy_end = T; ok = 1'b0; end
    end
    for (int k = 0; k <= busy_end + 1; k++) begin
      @(negedge clk);
      ld_req        = (k <= busy_end) || hold_req;
      ld_addr       = a;
      ld_funct3     = f3;
      mem_req_ready = legal && (k == rd + 1);
      real_rsp      = legal && (k == rd + wd + 2);
      // spurious responses while idle/requesting must be ignored
      mem_rsp_valid = real_rsp ? 1'b1 : ((k <= rd + 1) ? 1'($urandom_range(0, 1)) : 1'b0);
      mem_rsp_data  = real_rsp ? w : $urandom;
      #1;
      exp_mrv = legal && k >= 1 && k <= req_end;
      if (k == busy_end + 1) exp_data = ok ? ref_ext(f3, a, w) : 32'h0;
      chk({tag, ".stall"}, 32'(ld_stall), 32'(k <= busy_end));
      chk({tag, ".mrv"},   32'(mem_req_valid), 32'(exp_mrv));
      chk({tag, ".done"},  32'(ld_done), 32'(ok && k == busy_end + 1));
      chk({tag, ".err"},   32'(ld_err), 32'(!ok && k == busy_end + 1));
      chk({tag, ".data"},  ld_data, exp_data);
      if (exp_mrv) chk({tag, ".maddr"}, mem_addr, a & 32'hFFFF_FFFC);
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      ld_req = 1'b0; mem_req_ready = 1'($urandom_range(0, 1));
      mem_rsp_valid = 1'($urandom_range(0, 1)); mem_rsp_data = $urandom;
      #1;
      chk("idle.stall", 32'(ld_stall), 32'h0);
      chk("idle.mrv",   32'(mem_req_valid), 32'h0);
      chk("idle.done",  32'(ld_done), 32'h0);
      chk("idle.err",   32'(ld_err), 32'h0);
      chk("idle.data",  ld_data, exp_data);
    end
  endtask

  // Reset while in REQ (in_wait=0) or WAIT (in_wait=1), then a stale response.
  task automatic reset_mid(input bit in_wait, input string tag);
    @(negedge clk);
    ld_req = 1'b1; ld_addr = 32'h200; ld_funct3 = 3'b010;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
    @(negedge clk);
    mem_req_ready = in_wait;
    #1;
    chk({tag, ".pre_mrv"}, 32'(mem_req_valid), 32'h1);
    if (in_wait) begin
      @(negedge clk);
      mem_req_ready = 1'b0;
      #1;
      chk({tag, ".wait_stall"}, 32'(ld_stall), 32'h1);
    end
    rst = 1'b1;
    #1;
    exp_data = '0;
    chk({tag, ".rst_mrv"},   32'(mem_req_valid), 32'h0);
    chk({tag, ".rst_stall"}, 32'(ld_stall), 32'h0);
    chk({tag, ".rst_done"},  32'(ld_done), 32'h0);
    chk({tag, ".rst_err"},   32'(ld_err), 32'h0);
    chk({tag, ".rst_data"},  ld_data, 32'h0);
    @(negedge clk);
    rst = 1'b0; ld_req = 1'b0;
    @(negedge clk);
    mem_rsp_valid = 1'b1; mem_rsp_data = 32'h1234_5678;
    idle_cycles(3);
  endtask

  initial begin
    rst = 1'b1; ld_req = 1'b1; ld_addr = 32'h100; ld_funct3 = 3'b010;
    mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_data = '0;
    #22;
    chk("reset.stall", 32'(ld_stall), 32'h0);
    chk("reset.mrv",   32'(mem_req_valid), 32'h0);
    chk("reset.done",  32'(ld_done), 32'h0);
    chk("reset.err",   32'(ld_err), 32'h0);
    chk("reset.data",  ld_data, 32'h0);
    chk("reset.maddr", mem_addr, 32'h0);
    @(negedge clk);
    rst = 1'b0; ld_req = 1'b0;
    idle_cycles(2);

    run_load(32'h100, 3'b010, 32'hDEAD_BEEF, 0, 0, 1'b0, "lw_min");
    idle_cycles(1);
    run_load(32'h103, 3'b000, 32'h80AB_CD12, 0, 0, 1'b0, "lb_103");
    run_load(32'h103, 3'b100, 32'h80AB_CD12, 0, 0, 1'b0, "lbu_103");
    run_load(32'h102, 3'b001, 32'h8001_7FFF, 1, 2, 1'b0, "lh_102");
    run_load(32'h100, 3'b101, 32'h8001_7FFF, 0, 1, 1'b0, "lhu_100");
    run_load(32'h101, 3'b010, 32'h5555_5555, 0, 0, 1'b0, "lw_misal");
    run_load(32'h100, 3'b011, 32'h5555_5555, 0, 0, 1'b0, "f3_011");
    run_load(32'h103, 3'b001, 32'h5555_5555, 0, 0, 1'b0, "lh_misal");
    run_load(32'h240, 3'b010, 32'hCAFE_F00D, 3, 3, 1'b0, "lw_delay");
    run_load(32'h300, 3'b010, 32'h1111_2222, 0, 100, 1'b0, "no_rsp");
    run_load(32'h304, 3'b010, 32'h3333_4444, 2, T - 4, 1'b0, "rsp_at_tmo");
    run_load(32'h308, 3'b010, 32'h5555_6666, T - 1, 0, 1'b0, "rdy_at_tmo");
    run_load(32'h30C, 3'b010, 32'h7777_8888, T + 4, 0, 1'b0, "no_rdy");
    run_load(32'h400, 3'b010, 32'hA5A5_5A5A, 0, 0, 1'b1, "b2b_a");
    run_load(32'h402, 3'b001, 32'hFEDC_BA98, 0, 0, 1'b1, "b2b_b");
    run_load(32'h401, 3'b000, 32'h0102_8304, 1, 0, 1'b0, "b2b_c");
    idle_cycles(1);

    reset_mid(1'b0, "rst_req");
    reset_mid(1'b1, "rst_wait");

    for (int i = 0; i < 80; i++) begin
      logic [31:0] a, w;
      logic [2:0] f3;
      int rd, wd;
      a  = $urandom;
      w  = $urandom;
      f3 = 3'($urandom_range(0, 7));
      rd = ($urandom_range(0, 9) == 0) ? $urandom_range(0, T + 2) : $urandom_range(0, 4);
      wd = ($urandom_range(0, 9) == 0) ? $urandom_range(0, T + 2) : $urandom_range(0, 5);
      run_load(a, f3, w, rd, wd, 1'($urandom_range(0, 1)), "rand");
      if ($urandom_range(0, 3) == 0) idle_cycles($urandom_range(1, 2));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
